// File: rtl/reg_write_arbiter.sv
// Round-robin sequencer that gives N requesters one-cycle write access to a
// shared falling-edge register. Each transfer takes three states: IDLE, WRITE, DONE.
module reg_write_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   wdata,
  output logic             load,
  output logic [W-1:0]     x,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     ack,
  output logic             busy,
  output logic [IW-1:0]    last_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [IW-1:0] last_id_q, last_id_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [W-1:0]  x_q, x_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   idx;

  // Scan ptr, ptr+1, ... wrapping at N; the first set request wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    last_id_d = last_id_q;
    grant_d   = grant_q;
    x_d       = x_q;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          x_d           = wdata[pick*W +: W];
          win_d         = pick;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        state_d = DONE;
      end
      DONE: begin
        ptr_d     = (win_q == IW'(N-1)) ? '0 : win_q + 1'b1;
        last_id_d = win_q;
        grant_d   = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      last_id_q <= '0;
      grant_q   <= '0;
      x_q       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      last_id_q <= last_id_d;
      grant_q   <= grant_d;
      x_q       <= x_d;
    end
  end

  // Strobes decode only from flops so nothing combinational reaches the register.
  assign load    = (state_q == WRITE);
  assign ack     = (state_q == DONE) ? grant_q : '0;
  assign busy    = (state_q != IDLE);
  assign x       = x_q;
  assign grant   = grant_q;
  assign last_id = last_id_q;

endmodule
